// File: rtl/adds_seq.sv
// Chunk-serial two's complement adder/subtractor: CW bits per clock over N = W/CW cycles,
// with registered sum, raw carry out, signed overflow and optional saturation.
module adds_seq #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  input  logic         sat,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         over_flow
);

  localparam int unsigned N  = W / CW;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(N - 1);
  localparam logic [W-1:0]  MaxNeg  = {1'b1, {(W - 1){1'b0}}};
  localparam logic [W-1:0]  MaxPos  = ~MaxNeg;

  if ((W % CW) != 0) begin : gen_bad_width
    $error("adds_seq: W must be an integer multiple of CW");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic [W-1:0]  s_q, s_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          a_msb_q, a_msb_d;
  logic          sat_q, sat_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;

  logic [CW:0]      chunk_sum;
  logic [W+CW-1:0]  shift_cat;
  logic [W-1:0]     shifted_sum;
  logic             msb_cin;
  logic             ovf_now;
  logic             load;

  // Operands shift right one chunk per cycle, so the active chunk is always the low CW bits.
  assign chunk_sum   = {1'b0, a_q[CW-1:0]} + {1'b0, b_q[CW-1:0]} + {{CW{1'b0}}, carry_q};
  // Partial sum shifts in from the top; after N chunks it is fully aligned.
  assign shift_cat   = {chunk_sum[CW-1:0], sum_q};
  assign shifted_sum = shift_cat[W+CW-1:CW];
  // Carry into the chunk MSB recovered from sum bit and operand bits.
  assign msb_cin     = chunk_sum[CW-1] ^ a_q[CW-1] ^ b_q[CW-1];
  assign ovf_now     = msb_cin ^ chunk_sum[CW];
  assign load        = start && (state_q != StRun);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    s_d     = s_q;
    idx_d   = idx_q;
    a_msb_d = a_msb_q;
    sat_d   = sat_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: ;
      StRun: begin
        a_d     = a_q >> CW;
        b_d     = b_q >> CW;
        sum_d   = shifted_sum;
        carry_d = chunk_sum[CW];
        idx_d   = idx_q + IW'(1);
        if (idx_q == LastIdx) begin
          state_d = StDone;
          idx_d   = '0;
          cout_d  = chunk_sum[CW];
          ovf_d   = ovf_now;
          if (sat_q && ovf_now) begin
            s_d = a_msb_q ? MaxNeg : MaxPos;
          end else begin
            s_d = shifted_sum;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Acceptance from IDLE, or from DONE for back-to-back operation.
    if (load) begin
      state_d = StRun;
      a_d     = a;
      b_d     = b ^ {W{sel}};
      a_msb_d = a[W-1];
      sat_d   = sat;
      carry_d = sel;
      idx_d   = '0;
      sum_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      a_msb_q <= 1'b0;
      sat_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      a_msb_q <= a_msb_d;
      sat_q   <= sat_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign s         = s_q;
  assign cout      = cout_q;
  assign over_flow = ovf_q;

endmodule

// File: tb/tb_adds_seq.sv
// Bench for adds_seq: W=16/CW=4 and W=4/CW=4 instances, directed and random operations
// checked against an integer-arithmetic reference model.
module tb_adds_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, sel, sat;
  logic [15:0] a, b, s;
  logic        busy, done, cout, ovf;

  logic        start4, sel4, sat4;
  logic [3:0]  a4, b4, s4;
  logic        busy4, done4, cout4, ovf4;

  adds_seq #(.W(16), .CW(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sel(sel), .sat(sat),
    .busy(busy), .done(done), .s(s), .cout(cout), .over_flow(ovf)
  );

  adds_seq #(.W(4), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .sel(sel4), .sat(sat4),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4), .over_flow(ovf4)
  );

  typedef struct packed {
    logic        ovf;
    logic        cout;
    logic [15:0] s;
  } res_t;

  int   nvec = 0;
  int   nerr = 0;
  res_t last16 = '0;
  res_t last4  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signed/unsigned integer arithmetic on w-bit operands.
  function automatic res_t model(input int w, input logic [15:0] ta, input logic [15:0] tb_,
                                 input logic tsel, input logic tsat);
    res_t   r;
    longint m, ua, ub, sa, sb, v, hi, lo;
    m  = longint'(1) << w;
    ua = longint'(ta) & (m - 1);
    ub = longint'(tb_) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    v  = tsel ? sa - sb : sa + sb;
    hi = m / 2 - 1;
    lo = -(m / 2);
    r.ovf  = (v > hi) || (v < lo);
    r.cout = tsel ? (ua >= ub) : (ua + ub >= m);
    if (tsat && r.ovf) v = (v < 0) ? lo : hi;
    r.s = 16'(v & (m - 1));
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch in the current cycle; returns in the done cycle (N+1) with start low.
  task automatic op16(input logic [15:0] ta, input logic [15:0] tb_, input logic tsel,
                      input logic tsat);
    res_t e;
    e = model(16, ta, tb_, tsel, tsat);
    start = 1'b1; a = ta; b = tb_; sel = tsel; sat = tsat;
    step();
    for (int c = 1; c <= 4; c++) begin
      a = 16'($urandom); b = 16'($urandom); sel = 1'($urandom); sat = 1'($urandom);
      start = (c == 2);
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      chk("s_hold_run", s, last16.s);
      chk("flags_hold_run", {ovf, cout}, {last16.ovf, last16.cout});
      step();
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk("s", s, e.s);
    chk("cout", cout, e.cout);
    chk("over_flow", ovf, e.ovf);
    last16 = e;
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb_, input logic tsel,
                     input logic tsat);
    res_t e;
    e = model(4, {12'b0, ta}, {12'b0, tb_}, tsel, tsat);
    start4 = 1'b1; a4 = ta; b4 = tb_; sel4 = tsel; sat4 = tsat;
    step();
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
    chk("busy4_run", busy4, 1);
    chk("done4_run", done4, 0);
    chk("s4_hold_run", s4, last4.s[3:0]);
    step();
    chk("done4_pulse", done4, 1);
    chk("busy4_done", busy4, 0);
    chk("s4", s4, e.s[3:0]);
    chk("cout4", cout4, e.cout);
    chk("over_flow4", ovf4, e.ovf);
    last4 = e;
  endtask

  task automatic idle_check();
    step();
    chk("done_idle", done, 0);
    chk("busy_idle", busy, 0);
    chk("s_hold_idle", s, last16.s);
  endtask

  logic [15:0] corners [5];

  initial begin
    corners[0] = 16'h7FFF; corners[1] = 16'h8000; corners[2] = 16'hFFFF;
    corners[3] = 16'h0000; corners[4] = 16'h0001;
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; sel = 1'b0; sat = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; sel4 = 1'b0; sat4 = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_s4", s4, 0);
    step();
    step();
    rst_n = 1'b1;

    op16(16'h1234, 16'h0001, 1'b0, 1'b0);
    chk("d31_s", s, 16'h1235); chk("d31_cout", cout, 0); chk("d31_ovf", ovf, 0);
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0);  // back-to-back: done in cycle 10
    chk("d32a_s", s, 16'h0000); chk("d32a_cout", cout, 1); chk("d32a_ovf", ovf, 0);
    idle_check();
    op16(16'h0005, 16'h0007, 1'b1, 1'b0);
    chk("d32b_s", s, 16'hFFFE); chk("d32b_cout", cout, 0); chk("d32b_ovf", ovf, 0);
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("d33a_s", s, 16'h8000); chk("d33a_cout", cout, 0); chk("d33a_ovf", ovf, 1);
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b1);
    chk("d33b_s", s, 16'h7FFF); chk("d33b_cout", cout, 0); chk("d33b_ovf", ovf, 1);
    op16(16'h8000, 16'h0001, 1'b1, 1'b1);
    chk("d34_s", s, 16'h8000); chk("d34_cout", cout, 1); chk("d34_ovf", ovf, 1);
    idle_check();

    // Abort in cycle 3 of a run; no done may follow.
    start = 1'b1; a = 16'h1111; b = 16'h2222; sel = 1'b0; sat = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_s", s, 0);
    chk("abort_cout", cout, 0);
    chk("abort_ovf", ovf, 0);
    last16 = '0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("abort_no_done", done, 0);
    end
    rst_n = 1'b1;
    op16(16'h00F0, 16'h0F0F, 1'b0, 1'b0);  // accepted on first edge after release

    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
      op16(ra, rb, 1'($urandom), 1'($urandom));
      for (int g = $urandom_range(0, 2); g > 0; g--) idle_check();
    end

    op4(4'h7, 4'h1, 1'b0, 1'b0);
    chk("d36a_s4", s4, 4'h8); chk("d36a_ovf4", ovf4, 1);
    op4(4'h7, 4'h1, 1'b0, 1'b1);
    chk("d36b_s4", s4, 4'h7); chk("d36b_ovf4", ovf4, 1);
    for (int i = 0; i < 12; i++) begin
      op4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/adds_seq.md
ADDS_SEQ -- requirements
Module: adds_seq

Interface
REQ-001 Parameter W, default 16: operand and result width in bits.
REQ-002 Parameter CW, default 4: chunk width added per clock; W SHALL be an integer multiple of CW, with N = W/CW.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new operation; sampled on clk.
REQ-006 a  input  W  operand A, two's complement.
REQ-007 b  input  W  operand B, two's complement.
REQ-008 sel  input  1  0 = A+B, 1 = A-B.
REQ-009 sat  input  1  1 = saturate the result on signed overflow.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse; results are valid from this cycle.
REQ-012 s  output  W  result.
REQ-013 cout  output  1  raw carry out of bit W-1 (for subtract, 1 = no borrow).
REQ-014 over_flow  output  1  signed overflow flag.

Function
REQ-015 The block SHALL have three states: IDLE, RUN, DONE.
REQ-016 IDLE, start=1: latch a, b XOR {W{sel}}, sel, sat; set carry = sel and chunk index = 0; go to RUN.
REQ-017 RUN, each cycle: add chunk[idx] of A, chunk[idx] of B' and the carry; store the CW-bit partial sum; carry <= chunk carry out; idx++.
REQ-018 RUN SHALL last exactly N cycles; after chunk N-1 the FSM SHALL go to DONE.
REQ-019 DONE SHALL last one cycle: done=1, then go to IDLE, or straight back to RUN if start=1 in that cycle (back-to-back operation).
REQ-020 Latency: start sampled in cycle 0; busy=1 in cycles 1..N; done=1 and busy=0 in cycle N+1.
REQ-021 start while in RUN SHALL be ignored, with no effect on the operands or the result.
REQ-022 Input operands are captured only at acceptance; later changes to a, b, sel and sat SHALL NOT affect the operation in flight.
REQ-023 over_flow SHALL be the carry into bit W-1 XOR the carry out of bit W-1.
REQ-024 cout SHALL always report the raw carry out, unaffected by sat.
REQ-025 When sat=1 and over_flow=1, s SHALL be the most negative value (1 followed by W-1 zeros) if the latched a[W-1]=1, else the most positive value (0 followed by W-1 ones); over_flow SHALL still read 1.
REQ-026 s, cout and over_flow SHALL be registered, SHALL update only on entry to DONE, and SHALL hold until the next DONE; partial sums SHALL never be visible on s.
REQ-027 For N=1 (CW=W), RUN SHALL last one cycle and every rule above SHALL still apply.

Reset
REQ-028 rst_n=0 SHALL immediately force: state IDLE, busy=0, done=0, s=0, cout=0, over_flow=0, and the internal carry and index to 0.
REQ-029 Reset during RUN or DONE SHALL abort the operation; no done pulse SHALL follow for that operation.
REQ-030 After rst_n rises, the first start SHALL be accepted on the first rising clk edge at which it is sampled high.

Verification (W=16, CW=4)
REQ-031 a=0x1234, b=0x0001, sel=0, start in cycle 0 -> busy in cycles 1-4, done in cycle 5, s=0x1235, cout=0, over_flow=0.
REQ-032 a=0xFFFF, b=0x0001, sel=0 -> s=0x0000, cout=1, over_flow=0 (carry ripples through all 4 chunks); a=0x0005, b=0x0007, sel=1 -> s=0xFFFE, cout=0, over_flow=0.
REQ-033 a=0x7FFF, b=0x0001, sel=0 -> with sat=0: s=0x8000, over_flow=1, cout=0; with sat=1: s=0x7FFF, over_flow=1, cout=0.
REQ-034 a=0x8000, b=0x0001, sel=1, sat=1 -> s=0x8000, over_flow=1, cout=1.
REQ-035 Start pulsed again in cycle 2 with different operands -> ignored, cycle-5 result unchanged; start held high in cycle 5 -> second done in cycle 10; rst_n=0 in cycle 3 -> busy=0 at once, no done, all outputs 0.
REQ-036 Repeat REQ-031 and REQ-033 with W=4, CW=4 (a=0x7, b=0x1, sel=0) -> done in cycle 2; sat=0: s=0x8, over_flow=1; sat=1: s=0x7.
